// File: rtl/freq_div.sv
// Programmable divider and period meter: div_out toggles every 2^n rising edges
// of a synchronised sig_in, and the div_out period is measured in ref_clk cycles.
module freq_div #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             ref_clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             en,
    input  logic [2:0]       n,
    output logic             div_out,
    output logic [CNT_W-1:0] per,
    output logic             per_valid,
    output logic             per_ovf,
    output logic             lock
);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             s1, s2, s3, rise;
    logic [2:0]       n_l;
    logic [6:0]       edge_cnt, edge_term;
    logic [CNT_W-1:0] idle_cnt, per_cnt;
    logic             meter_on;
    logic             do_edge, do_toggle, timeout, clear_all, latch_n;

    // 7-bit wrap makes n_l=7 give 127 as the terminal count
    assign edge_term = (7'd1 << n_l) - 7'd1;

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = ARM;
            ARM:     if (!en) state_nxt = IDLE;
                     else if (rise) state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
                     else if (timeout) state_nxt = ARM;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        do_edge   = 1'b0;
        do_toggle = 1'b0;
        timeout   = 1'b0;
        clear_all = 1'b0;
        latch_n   = 1'b0;
        case (state)
            IDLE: begin
                clear_all = 1'b1;
                latch_n   = en;
            end
            ARM, RUN: begin
                if (!en) begin
                    clear_all = 1'b1;
                end else begin
                    do_edge   = rise;
                    do_toggle = rise && (edge_cnt == edge_term);
                    timeout   = (state == RUN) && !rise && (idle_cnt == TO_M1);
                    latch_n   = (rise && (edge_cnt == edge_term)) ||
                                ((state == RUN) && !rise && (idle_cnt == TO_M1));
                end
            end
            default: clear_all = 1'b1;
        endcase
    end

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            rise      <= 1'b0;
            n_l       <= 3'd0;
            edge_cnt  <= 7'd0;
            idle_cnt  <= '0;
            per_cnt   <= '0;
            meter_on  <= 1'b0;
            div_out   <= 1'b0;
            per       <= '0;
            per_valid <= 1'b0;
            per_ovf   <= 1'b0;
            lock      <= 1'b0;
        end else begin
            s1        <= sig_in;
            s2        <= s1;
            s3        <= s2;
            // registered edge strobe: a rise acts 3 edges after sig_in is first sampled
            rise      <= s2 & ~s3;
            per_valid <= 1'b0;
            if (latch_n) n_l <= n;

            if (clear_all) begin
                div_out  <= 1'b0;
                edge_cnt <= 7'd0;
                idle_cnt <= '0;
                per_cnt  <= '0;
                meter_on <= 1'b0;
                lock     <= 1'b0;
            end else if (timeout) begin
                div_out  <= 1'b0;
                edge_cnt <= 7'd0;
                idle_cnt <= TO_VAL;
                per_cnt  <= '0;
                meter_on <= 1'b0;
                lock     <= 1'b0;
            end else begin
                if (rise)                    idle_cnt <= '0;
                else if (idle_cnt != TO_VAL) idle_cnt <= idle_cnt + 1'b1;

                if (do_edge) edge_cnt <= do_toggle ? 7'd0 : edge_cnt + 7'd1;
                if (do_toggle) div_out <= ~div_out;

                if (do_toggle && !div_out) begin
                    per_cnt <= '0;
                    if (!meter_on) begin
                        meter_on <= 1'b1;
                    end else begin
                        per       <= (&per_cnt) ? '1 : per_cnt + 1'b1;
                        per_ovf   <= &per_cnt;
                        per_valid <= 1'b1;
                        lock      <= 1'b1;
                    end
                end else if (meter_on && !(&per_cnt)) begin
                    per_cnt <= per_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_div.sv
// Bench for freq_div: square-wave generator on sig_in, expected periods computed
// from 2^(n+1) * sig period with saturation at the counter width.
module tb_freq_div;
    localparam int CW   = 12;
    localparam int TO   = 1000;
    localparam int MAXP = (1 << CW) - 1;

    logic          ref_clk, rst, sig_in, en;
    logic [2:0]    n;
    logic          div_out, per_valid, per_ovf, lock;
    logic [CW-1:0] per;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit gen_on = 0;
    int gen_hi = 5, gen_lo = 5, ph = 0;

    freq_div #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .ref_clk(ref_clk), .rst(rst), .sig_in(sig_in), .en(en), .n(n),
        .div_out(div_out), .per(per), .per_valid(per_valid),
        .per_ovf(per_ovf), .lock(lock)
    );

    initial begin
        ref_clk = 0;
        forever #5 ref_clk = ~ref_clk;
    end

    initial forever begin
        @(posedge ref_clk);
        cyc++;
    end

    initial forever begin
        @(negedge ref_clk);
        if (gen_on) begin
            sig_in = (ph < gen_hi);
            ph = (ph + 1 >= gen_hi + gen_lo) ? 0 : ph + 1;
        end
    end

    function automatic int exp_per(input int nn, input int p);
        int t = (1 << (nn + 1)) * p;
        return (t > MAXP) ? MAXP : t;
    endfunction

    function automatic bit exp_ovf(input int nn, input int p);
        return ((1 << (nn + 1)) * p) > MAXP;
    endfunction

    task automatic wait_valid(input int bound, output bit got, output int rises);
        bit prev = div_out;
        got = 0;
        rises = 0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge ref_clk);
            if (div_out && !prev) rises++;
            prev = div_out;
            if (per_valid) got = 1;
        end
    endtask

    task automatic restart(input int nn, input int hi, input int lo);
        gen_on = 0;
        @(negedge ref_clk);
        sig_in = 0;
        en = 0;
        repeat (3) @(negedge ref_clk);
        n = nn[2:0];
        en = 1;
        repeat (2) @(negedge ref_clk);
        gen_hi = hi;
        gen_lo = lo;
        ph = 0;
        gen_on = 1;
    endtask

    task automatic test_reset;
        rst = 1; en = 0; n = 0; sig_in = 0;
        repeat (3) @(negedge ref_clk);
        checks++;
        if ({div_out, per_valid, per_ovf, lock} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got div/valid/ovf/lock=%b expected 0000",
                     {div_out, per_valid, per_ovf, lock});
        end
        checks++;
        if (per !== '0) begin
            errors++;
            $display("FAIL reset_per: got %0d expected 0", per);
        end
        @(negedge ref_clk);
        rst = 0;
    endtask

    task automatic test_latency;
        en = 1; n = 0;
        repeat (2) @(negedge ref_clk);
        sig_in = 1;
        repeat (3) @(negedge ref_clk);
        checks++;
        if (div_out !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: div_out got %b expected 0 two edges after sampling", div_out);
        end
        @(negedge ref_clk);
        checks++;
        if (div_out !== 1'b1 || lock !== 1'b0 || per_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_toggle: div/lock/valid got %b%b%b expected 100",
                     div_out, lock, per_valid);
        end
        repeat (2) @(negedge ref_clk);
        sig_in = 0;
    endtask

    task automatic run_and_check(input string tag, input int nn, input int p);
        bit got;
        int r;
        int e = exp_per(nn, p);
        for (int k = 0; k < 2; k++) begin
            wait_valid(8 * (1 << (nn + 1)) * p + 64, got, r);
            checks++;
            if (!got || per !== CW'(e) || per_ovf !== exp_ovf(nn, p)) begin
                errors++;
                $display("FAIL %s_per: n=%0d p=%0d got valid=%b per=%0d ovf=%b expected per=%0d ovf=%b",
                         tag, nn, p, got, per, per_ovf, e, exp_ovf(nn, p));
            end
            @(negedge ref_clk);
            checks++;
            if (per_valid !== 1'b0 || lock !== 1'b1) begin
                errors++;
                $display("FAIL %s_pulse: valid/lock got %b%b expected 01", tag, per_valid, lock);
            end
        end
    endtask

    task automatic test_overflow;
        int hi = $urandom_range(9, 12);
        int lo = $urandom_range(9, 12);
        restart(7, hi, lo);
        run_and_check("overflow", 7, hi + lo);
    endtask

    task automatic test_divide;
        for (int it = 0; it < 6; it++) begin
            int nn = (it == 0) ? 0 : (it == 1) ? 2 : $urandom_range(0, 3);
            int hi = (it < 2) ? 5 : $urandom_range(2, 7);
            int lo = (it < 2) ? 5 : $urandom_range(2, 7);
            restart(nn, hi, lo);
            run_and_check("divide", nn, hi + lo);
        end
    endtask

    task automatic test_n_change;
        bit got;
        int r;
        int exp_a = ((1 << 2) + (1 << 1)) * 10;
        int exp_b = (1 << 2) * 10;
        restart(2, 5, 5);
        wait_valid(400, got, r);
        checks++;
        if (!got || per !== CW'(80)) begin
            errors++;
            $display("FAIL nchg_first: got valid=%b per=%0d expected 80", got, per);
        end
        repeat (15) @(negedge ref_clk);
        n = 1;
        wait_valid(400, got, r);
        checks++;
        if (!got || per !== CW'(exp_a)) begin
            errors++;
            $display("FAIL nchg_mixed: got valid=%b per=%0d expected %0d", got, per, exp_a);
        end
        wait_valid(400, got, r);
        checks++;
        if (!got || per !== CW'(exp_b)) begin
            errors++;
            $display("FAIL nchg_new: got valid=%b per=%0d expected %0d", got, per, exp_b);
        end
    endtask

    task automatic test_timeout;
        bit got;
        int r, e0;
        restart(1, 5, 5);
        wait_valid(400, got, r);
        e0 = cyc;
        gen_on = 0;
        sig_in = 0;
        checks++;
        if (!got || per !== CW'(40)) begin
            errors++;
            $display("FAIL tmo_setup: got valid=%b per=%0d expected 40", got, per);
        end
        for (int i = 0; i < 1100 && cyc < e0 + TO - 1; i++) @(negedge ref_clk);
        checks++;
        if (lock !== 1'b1 || div_out !== 1'b1) begin
            errors++;
            $display("FAIL tmo_before: lock/div got %b%b expected 11 at %0d cycles", lock, div_out, cyc - e0);
        end
        @(negedge ref_clk);
        checks++;
        if (lock !== 1'b0 || div_out !== 1'b0 || per !== CW'(40)) begin
            errors++;
            $display("FAIL tmo_fire: lock/div got %b%b per=%0d expected 00 per=40", lock, div_out, per);
        end
        repeat (50) @(negedge ref_clk);
        checks++;
        if (lock !== 1'b0 || per_valid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_hold: lock/valid got %b%b expected 00", lock, per_valid);
        end
        ph = 0;
        gen_on = 1;
        wait_valid(400, got, r);
        checks++;
        if (!got || r != 2 || per !== CW'(40)) begin
            errors++;
            $display("FAIL tmo_relock: valid=%b rises=%0d per=%0d expected 1, 2 rises, per=40", got, r, per);
        end
        @(negedge ref_clk);
        checks++;
        if (lock !== 1'b1) begin
            errors++;
            $display("FAIL tmo_lock: lock got %b expected 1", lock);
        end
    endtask

    task automatic test_en_drop;
        bit got;
        int r;
        restart(1, 5, 5);
        wait_valid(400, got, r);
        @(negedge ref_clk);
        en = 0;
        @(negedge ref_clk);
        checks++;
        if (div_out !== 1'b0 || lock !== 1'b0 || per !== CW'(40) || per_valid !== 1'b0) begin
            errors++;
            $display("FAIL endrop: div/lock/valid got %b%b%b per=%0d expected 000 per=40",
                     div_out, lock, per_valid, per);
        end
        n = 0;
        en = 1;
        wait_valid(400, got, r);
        checks++;
        if (!got || per !== CW'(20)) begin
            errors++;
            $display("FAIL endrop_fresh_n: valid=%b per=%0d expected per=20", got, per);
        end
    endtask

    task automatic test_rst_mid;
        bit got, saw;
        int r;
        restart(2, 5, 5);
        wait_valid(400, got, r);
        repeat (15) @(negedge ref_clk);
        rst = 1;
        #1;
        checks++;
        if ({div_out, per_valid, per_ovf, lock} !== 4'b0000 || per !== '0) begin
            errors++;
            $display("FAIL rstmid_async: div/valid/ovf/lock=%b per=%0d expected 0000 per=0",
                     {div_out, per_valid, per_ovf, lock}, per);
        end
        saw = 0;
        repeat (3) begin
            @(negedge ref_clk);
            if (per_valid) saw = 1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_valid: per_valid seen %b expected 0", saw);
        end
        rst = 0;
        wait_valid(600, got, r);
        checks++;
        if (!got || per !== CW'(80) || per_ovf !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_resume: valid=%b per=%0d ovf=%b expected per=80 ovf=0", got, per, per_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_divide();
        test_n_change();
        test_timeout();
        test_en_drop();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
